// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS15 (x^15+x^14+1) byte-stream checker.
// Seeds a local predictor from two received bytes and verifies the following
// bytes. Declares lock after a run of clean bytes, then counts bit errors and
// detects loss of lock.
// Optional build macro PRBS_CHK_INV_EN adds an 'inv' input that inverts
// data_in before it is used, for links with inverted polarity.
module prbs_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_CNT    = 4,
  parameter int LOSS_THRESH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       data_in,
  input  logic             valid,
  input  logic             clear,
`ifdef PRBS_CHK_INV_EN
  input  logic             inv,
`endif
  output logic             locked,
  output logic [3:0]       bit_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    ST_SEED,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t           r_state, w_state_next;
  logic [14:0]      r_hist, w_hist_next;      // r_hist[0] is the newest bit
  logic             r_seed_cnt, w_seed_cnt_next;
  logic [GW-1:0]    r_good_cnt, w_good_cnt_next;
  logic [BW-1:0]    r_bad_cnt, w_bad_cnt_next;
  logic [3:0]       r_bit_err, w_bit_err_next;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_next;
  logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_next;

  logic [7:0]       w_data;
  logic [7:0]       w_pred;
  logic [7:0]       w_mis;
  logic [3:0]       w_pop;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W:0]   w_byte_sum;
  logic [CNT_W-1:0] w_err_sat;
  logic [CNT_W-1:0] w_byte_sat;

`ifdef PRBS_CHK_INV_EN
  assign w_data = data_in ^ {8{inv}};
`else
  assign w_data = data_in;
`endif

  // Unroll the serial recurrence b[k] = b[k-14] ^ b[k-15] over one byte.
  // ext[0] is the oldest history bit; ext[15..22] are the 8 predicted bits in
  // serial order, so the earliest lands in byte bit 7.
  always_comb begin
    logic [22:0] ext;
    ext    = '0;
    w_pred = '0;
    for (int i = 0; i < 15; i++) begin
      ext[i] = r_hist[14-i];
    end
    for (int j = 0; j < 8; j++) begin
      ext[15+j] = ext[j+1] ^ ext[j];
    end
    for (int j = 0; j < 8; j++) begin
      w_pred[7-j] = ext[15+j];
    end
  end

  // Per-lane mismatch between prediction and received byte.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mis
      assign w_mis[gi] = w_pred[gi] ^ w_data[gi];
    end
  endgenerate

  // Count mismatching lanes of the current byte.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'b000, w_mis[i]};
    end
  end

  // Saturating accumulators: the extra top bit flags overflow.
  assign w_err_sum  = {1'b0, r_err_cnt} + (CNT_W+1)'(w_pop);
  assign w_byte_sum = {1'b0, r_byte_cnt} + (CNT_W+1)'(1);
  assign w_err_sat  = w_err_sum[CNT_W]  ? '1 : w_err_sum[CNT_W-1:0];
  assign w_byte_sat = w_byte_sum[CNT_W] ? '1 : w_byte_sum[CNT_W-1:0];

  // Next-state logic for the sync FSM, predictor history and statistics.
  always_comb begin
    w_state_next    = r_state;
    w_hist_next     = r_hist;
    w_seed_cnt_next = r_seed_cnt;
    w_good_cnt_next = r_good_cnt;
    w_bad_cnt_next  = r_bad_cnt;
    w_bit_err_next  = r_bit_err;
    w_err_cnt_next  = r_err_cnt;
    w_byte_cnt_next = r_byte_cnt;

    if (valid) begin
      case (r_state)
        ST_SEED: begin
          // Received bits become the history; two bytes cover all 15 taps.
          w_hist_next = {r_hist[6:0], w_data};
          if (r_seed_cnt) begin
            w_state_next    = ST_VERIFY;
            w_seed_cnt_next = 1'b0;
            w_good_cnt_next = '0;
          end else begin
            w_seed_cnt_next = 1'b1;
          end
        end
        ST_VERIFY: begin
          // Advance on predicted bits so a received error cannot corrupt the seed.
          w_hist_next    = {r_hist[6:0], w_pred};
          w_bit_err_next = w_pop;
          if (w_pop == 4'd0) begin
            if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
              w_state_next   = ST_LOCKED;
              w_bad_cnt_next = '0;
            end else begin
              w_good_cnt_next = r_good_cnt + GW'(1);
            end
          end else begin
            w_state_next    = ST_SEED;
            w_seed_cnt_next = 1'b0;
          end
        end
        ST_LOCKED: begin
          w_hist_next     = {r_hist[6:0], w_pred};
          w_bit_err_next  = w_pop;
          w_err_cnt_next  = w_err_sat;
          w_byte_cnt_next = w_byte_sat;
          if (w_pop >= 4'(LOSS_THRESH)) begin
            if (r_bad_cnt == BW'(LOSS_CNT - 1)) begin
              w_state_next    = ST_SEED;
              w_seed_cnt_next = 1'b0;
              w_bad_cnt_next  = '0;
            end else begin
              w_bad_cnt_next = r_bad_cnt + BW'(1);
            end
          end else begin
            w_bad_cnt_next = '0;
          end
        end
        default: begin
          w_state_next    = ST_SEED;
          w_seed_cnt_next = 1'b0;
        end
      endcase
    end

    // Clear discards the old totals but keeps the contribution of a byte
    // being checked in the same cycle.
    if (clear) begin
      if (valid && (r_state == ST_LOCKED)) begin
        w_err_cnt_next  = CNT_W'(w_pop);
        w_byte_cnt_next = CNT_W'(1);
      end else begin
        w_err_cnt_next  = '0;
        w_byte_cnt_next = '0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_SEED;
      r_hist     <= '0;
      r_seed_cnt <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_bit_err  <= '0;
      r_err_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hist     <= w_hist_next;
      r_seed_cnt <= w_seed_cnt_next;
      r_good_cnt <= w_good_cnt_next;
      r_bad_cnt  <= w_bad_cnt_next;
      r_bit_err  <= w_bit_err_next;
      r_err_cnt  <= w_err_cnt_next;
      r_byte_cnt <= w_byte_cnt_next;
    end
  end

  assign locked   = (r_state == ST_LOCKED);
  assign bit_err  = r_bit_err;
  assign err_cnt  = r_err_cnt;
  assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed scenarios plus a randomized run against a
// bit-serial reference model of the PRBS15 checker.
module tb_prbs_checker;
  localparam int CNT_W = 32;
  localparam int M_SEED = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [7:0]       data_in;
  logic             valid;
  logic             clear;
  logic             locked;
  logic [3:0]       bit_err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] byte_cnt;
`ifdef PRBS_CHK_INV_EN
  logic             inv = 1'b0;
`endif

  prbs_checker #(.LOCK_CNT(4), .LOSS_CNT(4), .LOSS_THRESH(2), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .data_in  (data_in),
    .valid    (valid),
    .clear    (clear),
`ifdef PRBS_CHK_INV_EN
    .inv      (inv),
`endif
    .locked   (locked),
    .bit_err  (bit_err),
    .err_cnt  (err_cnt),
    .byte_cnt (byte_cnt)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (bit-serial) ----------------
  int     m_state;
  bit     m_q[$];          // last 15 bits of the reference sequence, oldest first
  int     m_seed, m_good, m_bad, m_bit_err;
  longint m_err, m_byte;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  function automatic void model_reset();
    m_state = M_SEED; m_q.delete();
    m_seed = 0; m_good = 0; m_bad = 0; m_bit_err = 0;
    m_err = 0; m_byte = 0;
  endfunction

  function automatic void model_step(input logic [7:0] d, input logic v, input logic clr);
    bit counted = 0;
    int errs = 0;
    if (v) begin
      if (m_state == M_SEED) begin
        for (int i = 7; i >= 0; i--) m_q.push_back(d[i]);
        while (m_q.size() > 15) void'(m_q.pop_front());
        m_seed++;
        if (m_seed == 2) begin m_state = M_VERIFY; m_seed = 0; m_good = 0; end
      end else begin
        for (int i = 7; i >= 0; i--) begin
          bit e;
          e = m_q[1] ^ m_q[0];    // b[k-14] ^ b[k-15]
          m_q.push_back(e);
          void'(m_q.pop_front());
          if (e != d[i]) errs++;
        end
        m_bit_err = errs;
        if (m_state == M_VERIFY) begin
          if (errs == 0) begin
            m_good++;
            if (m_good == 4) begin m_state = M_LOCKED; m_bad = 0; end
          end else begin
            m_state = M_SEED; m_seed = 0;
          end
        end else begin
          counted = 1;
          m_err  = (m_err + errs > MAXC) ? MAXC : m_err + errs;
          m_byte = (m_byte + 1 > MAXC) ? MAXC : m_byte + 1;
          if (errs >= 2) begin
            m_bad++;
            if (m_bad == 4) begin m_state = M_SEED; m_seed = 0; m_bad = 0; end
          end else begin
            m_bad = 0;
          end
        end
      end
    end
    if (clr) begin
      m_err  = counted ? longint'(errs) : 0;
      m_byte = counted ? 1 : 0;
    end
  endfunction

  // ---------------- stream generator ----------------
  bit          g_q[$];
  logic [14:0] g_seed;
  int          g_emit;

  function automatic void gen_init(input logic [14:0] s);
    g_seed = s; g_emit = 0; g_q.delete();
  endfunction

  function automatic logic [7:0] gen_byte();
    logic [7:0] b;
    b = '0;
    for (int i = 7; i >= 0; i--) begin
      bit e;
      if (g_emit < 15) begin
        e = g_seed[14-g_emit];
        g_emit++;
      end else begin
        e = g_q[g_q.size()-14] ^ g_q[g_q.size()-15];
      end
      g_q.push_back(e);
      if (g_q.size() > 15) void'(g_q.pop_front());
      b[i] = e;
    end
    return b;
  endfunction

  // ---------------- drivers ----------------
  task automatic check_outs(input string tag);
    chk({tag, ".locked"},   locked,   (m_state == M_LOCKED));
    chk({tag, ".bit_err"},  bit_err,  m_bit_err);
    chk({tag, ".err_cnt"},  err_cnt,  m_err);
    chk({tag, ".byte_cnt"}, byte_cnt, m_byte);
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic clr, input string tag);
    data_in = d; valid = v; clear = clr;
    @(posedge CLK);
    model_step(d, v, clr);
    #1;
    check_outs(tag);
    $display("%s d=%02h v=%0d clr=%0d locked=%0d bit_err=%0d err_cnt=%0d byte_cnt=%0d",
             tag, d, v, clr, locked, bit_err, err_cnt, byte_cnt);
  endtask

  initial begin
    int          sent;
    int          burst;
    logic [7:0]  mask;
    logic        v, c;

    RST = 1'b1; valid = 1'b0; clear = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.locked",   locked,   0);
    chk("rst.bit_err",  bit_err,  0);
    chk("rst.err_cnt",  err_cnt,  0);
    chk("rst.byte_cnt", byte_cnt, 0);
    $display("reset locked=%0d bit_err=%0d err_cnt=%0d byte_cnt=%0d", locked, bit_err, err_cnt, byte_cnt);
    RST = 1'b0;

    // All-ones seed: FF FE 00 04 ... locks one cycle after the 6th byte.
    gen_init(15'h7FFF);
    for (int i = 0; i < 6; i++) begin
      step(gen_byte(), 1'b1, 1'b0, "lock");
      if (i == 4) chk("lock.pre6", locked, 0);
    end
    chk("lock.after6", locked, 1);
    chk("lock.err0",   err_cnt, 0);

    // Single-bit error while locked.
    for (int i = 0; i < 3; i++) step(gen_byte(), 1'b1, 1'b0, "clean");
    step(gen_byte() ^ 8'h01, 1'b1, 1'b0, "flip0");
    chk("flip0.bit_err", bit_err, 1);
    chk("flip0.locked",  locked,  1);
    chk("flip0.err_cnt", err_cnt, 1);

    // Four consecutive 2-bit-error bytes drop lock.
    for (int i = 0; i < 4; i++) begin
      step(gen_byte() ^ 8'h03, 1'b1, 1'b0, "loss");
      chk("loss.bit_err", bit_err, 2);
      chk("loss.locked",  locked, (i < 3));
    end
    chk("loss.err_cnt",  err_cnt, 9);
    chk("loss.byte_cnt", byte_cnt, 8);

    // Error during VERIFY returns to SEED, then six clean bytes re-lock.
    for (int i = 0; i < 3; i++) step(gen_byte(), 1'b1, 1'b0, "verify");
    step(gen_byte() ^ 8'h10, 1'b1, 1'b0, "verr");
    chk("verr.locked", locked, 0);
    for (int i = 0; i < 6; i++) step(gen_byte(), 1'b1, 1'b0, "relock");
    chk("relock.locked", locked, 1);
    chk("relock.err_hold", err_cnt, 9);

    // valid toggling on a fresh random stream.
    RST = 1'b1; @(posedge CLK); #1; RST = 1'b0; model_reset();
    gen_init(15'($urandom_range(1, 32767)));
    sent = 0;
    while (sent < 6) begin
      step(8'($urandom), 1'b0, 1'b0, "gap");
      step(gen_byte(), 1'b1, 1'b0, "gapv");
      sent++;
    end
    chk("gap.locked", locked, 1);

    // clear together with a 3-error byte, then reset mid-stream.
    step(gen_byte(), 1'b1, 1'b0, "pre_clr");
    step(gen_byte() ^ 8'h07, 1'b1, 1'b1, "clr3");
    chk("clr3.err_cnt",  err_cnt, 3);
    chk("clr3.byte_cnt", byte_cnt, 1);
    data_in = gen_byte(); valid = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst2.locked",   locked,   0);
    chk("rst2.bit_err",  bit_err,  0);
    chk("rst2.err_cnt",  err_cnt,  0);
    chk("rst2.byte_cnt", byte_cnt, 0);
    $display("midrst locked=%0d bit_err=%0d err_cnt=%0d byte_cnt=%0d", locked, bit_err, err_cnt, byte_cnt);
    RST = 1'b0; model_reset();
    for (int i = 0; i < 6; i++) step(gen_byte(), 1'b1, 1'b0, "postrst");
    chk("postrst.locked", locked, 1);

    // Randomized traffic: gaps, sparse errors, loss bursts, clears, phase jumps.
    burst = 0;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) gen_init(15'($urandom));
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = 5;
      if (burst > 0) mask = 8'h03;
      else if ($urandom_range(0, 9) == 0) mask = 8'($urandom);
      else mask = 8'h00;
      if (v) begin
        if (burst > 0) burst--;
        step(gen_byte() ^ mask, 1'b1, c, "rnd");
      end else begin
        step(8'($urandom), 1'b0, c, "rnd");
      end
    end

    valid = 1'b0; clear = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
